// File: rtl/wave_bank_scheduler.sv
// Capture sequencer for the double-buffered 512x8 waveform RAM. It arms on a
// sample below the trigger level, starts a capture on the next sample at or
// above it (or on timeout), then writes 256 samples into the bank that is not
// displayed. After that it waits for an end-of-frame pulse and swaps banks.
module wave_bank_scheduler #(
  parameter logic [7:0]  TRIG_LEVEL = 8'd128,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       frame_done,
  output logic       write_enable,
  output logic [8:0] write_address,
  output logic [7:0] write_sample,
  output logic       read_index,
  output logic [1:0] state,
  output logic       trig_auto
);

  typedef enum logic [1:0] {
    ARMING  = 2'd0,
    ACTIVE  = 2'd1,
    CAPTURE = 2'd2,
    WAIT    = 2'd3
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [8:0]  addr_q;
  logic [7:0]  data_q;
  logic        read_index_q;
  logic        trig_auto_q;
  logic [7:0]  count_q;
  logic [15:0] tcnt_q;

  logic [15:0] tcnt_d;
  logic        above;
  logic        timeout_hit;

  // Trigger and timeout qualification for the sample currently on the input.
  always_comb begin
    tcnt_d      = tcnt_q + 16'd1;
    above       = (sample >= TRIG_LEVEL);
    timeout_hit = (TIMEOUT != 0) && ((32'(tcnt_q) + 32'd1) == TIMEOUT);
  end

  // Capture FSM with registered RAM write port and bank select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARMING;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      read_index_q <= 1'b0;
      trig_auto_q  <= 1'b0;
      count_q      <= '0;
      tcnt_q       <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ARMING, ACTIVE: begin
          if (sample_valid) begin
            tcnt_q <= tcnt_d;
            // A real trigger takes priority over a coincident timeout.
            if ((state_q == ACTIVE && above) || timeout_hit) begin
              we_q        <= 1'b1;
              addr_q      <= {~read_index_q, 8'd0};
              data_q      <= sample;
              count_q     <= 8'd1;
              trig_auto_q <= ~(state_q == ACTIVE && above);
              state_q     <= CAPTURE;
            end else if (state_q == ARMING && !above) begin
              state_q <= ACTIVE;
            end
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            we_q    <= 1'b1;
            addr_q  <= {~read_index_q, count_q};
            data_q  <= sample;
            count_q <= count_q + 8'd1;
            if (count_q == 8'd255) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (frame_done) begin
            read_index_q <= ~read_index_q;
            tcnt_q       <= '0;
            state_q      <= ARMING;
          end
        end
        default: state_q <= ARMING;
      endcase
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_sample  = data_q;
  assign read_index    = read_index_q;
  assign state         = state_q;
  assign trig_auto     = trig_auto_q;

endmodule

// File: tb/tb_wave_bank_scheduler.sv
// Randomized bench for wave_bank_scheduler with a behavioural capture model.
module tb_wave_bank_scheduler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       frame_done = 1'b0;
  logic       write_enable;
  logic [8:0] write_address;
  logic [7:0] write_sample;
  logic       read_index;
  logic [1:0] state;
  logic       trig_auto;

  logic       we0, ri0, ta0;
  logic [8:0] addr0;
  logic [7:0] data0;
  logic [1:0] state0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wave_bank_scheduler #(.TRIG_LEVEL(8'd128), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .frame_done(frame_done), .write_enable(write_enable),
    .write_address(write_address), .write_sample(write_sample),
    .read_index(read_index), .state(state), .trig_auto(trig_auto)
  );

  // Auto-trigger disabled: fed a constant above-threshold stream forever.
  wave_bank_scheduler #(.TRIG_LEVEL(8'd128), .TIMEOUT(0)) dut_noto (
    .clk(clk), .reset(reset), .sample(8'd200), .sample_valid(1'b1),
    .frame_done(1'b0), .write_enable(we0),
    .write_address(addr0), .write_sample(data0),
    .read_index(ri0), .state(state0), .trig_auto(ta0)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a capture is "armed" after a low sample, "capturing"
  // while fewer than 256 samples have been stored, "waiting" until the frame ends.
  bit       m_low, m_cap, m_wait, m_ri, m_auto;
  int       m_idx, m_since;
  bit       e_we;
  bit [8:0] e_addr;
  bit [7:0] e_data;

  function automatic int m_state_code();
    if (m_cap)  return 2;
    if (m_wait) return 3;
    if (m_low)  return 1;
    return 0;
  endfunction

  task automatic model_write(input bit [7:0] s);
    bit [7:0] ib;
    ib     = m_idx[7:0];
    e_we   = 1'b1;
    e_addr = {~m_ri, ib};
    e_data = s;
    m_idx++;
  endtask

  task automatic model_step(input bit v, input bit [7:0] s, input bit fd, input bit r);
    bit trig, tout;
    e_we = 1'b0;
    if (r) begin
      m_low = 0; m_cap = 0; m_wait = 0; m_ri = 0; m_auto = 0;
      m_idx = 0; m_since = 0; e_addr = '0; e_data = '0;
    end else if (m_cap) begin
      if (v) begin
        model_write(s);
        if (m_idx == 256) begin
          m_cap = 0; m_wait = 1; m_idx = 0;
        end
      end
    end else if (m_wait) begin
      if (fd) begin
        m_ri = ~m_ri; m_wait = 0; m_low = 0; m_since = 0;
      end
    end else if (v) begin
      m_since++;
      trig = m_low && (s >= 8'd128);
      tout = (TO != 0) && (m_since == TO);
      if (trig || tout) begin
        m_auto = !trig;
        m_cap  = 1;
        m_idx  = 0;
        model_write(s);
      end else if (s < 8'd128) begin
        m_low = 1;
      end
    end
  endtask

  task automatic cyc(input bit v, input bit [7:0] s, input bit fd, input bit r);
    sample_valid = v;
    sample       = s;
    frame_done   = fd;
    reset        = r;
    model_step(v, s, fd, r);
    @(posedge clk);
    #1;
    check("state", int'(state), m_state_code());
    check("read_index", int'(read_index), int'(m_ri));
    check("write_enable", int'(write_enable), int'(e_we));
    check("trig_auto", int'(trig_auto), int'(m_auto));
    if (e_we || r) begin
      check("write_address", int'(write_address), int'(e_addr));
      check("write_sample", int'(write_sample), int'(e_data));
    end
  endtask

  initial begin
    bit [7:0] s;
    // Reset from power-up.
    cyc(0, 8'd0, 0, 1);
    cyc(0, 8'd0, 0, 1);

    // Rising ramp: 100, 120 arm, 140 triggers at address 9'h100.
    for (int i = 0; i < 300; i++) begin
      s = 8'(100 + 20 * i);
      cyc(1, s, (i == 50) || (i == 150), 0);
    end
    cyc(0, 8'd0, 1, 0);                       // swap to read_index = 1

    // Start a capture in bank 0, then reset mid-capture.
    cyc(1, 8'd10, 0, 0);
    cyc(1, 8'd200, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(1, 8'd5, 0, 1);
    cyc(1, 8'd5, 0, 1);
    check("noto_state_after_reset", int'(state0), 0);

    // Constant above-threshold stream: timeout forces the capture.
    for (int i = 0; i < 16 + 256 + 4; i++) cyc(1, 8'd200, 0, 0);
    cyc(0, 8'd0, 1, 0);

    // Timeout-th sample is also a rising crossing: trigger wins.
    for (int i = 0; i < 15; i++) cyc(1, 8'd50, 0, 0);
    cyc(1, 8'd200, 0, 0);
    for (int i = 0; i < 260; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(0, 8'd0, 1, 0);

    // Sparse strobes every third cycle.
    for (int i = 0; i < 900; i++)
      cyc((i % 3) == 0, 8'($urandom), (i % 3) != 0 && ($urandom_range(0, 60) == 0), 0);

    // Fully random traffic with occasional frame ends and resets.
    for (int i = 0; i < 5000; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 39) == 0, $urandom_range(0, 2499) == 0);

    check("noto_state", int'(state0), 0);
    check("noto_write_enable", int'(we0), 0);
    check("noto_read_index", int'(ri0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_bank_scheduler.md
# wave_bank_scheduler

Capture sequencer for the double-buffered 512×8 waveform sample RAM. It triggers on a rising crossing of the incoming sample stream and writes 256 consecutive samples into the bank not currently displayed. After the capture it waits for the display's end-of-frame pulse and swaps banks by toggling `read_index`. It sits between the audio sample source and the RAM write port, and drives the `read_index` input of the waveform display.

## Interface
- `TRIG_LEVEL`, 8'd128: trigger threshold on unsigned offset-binary samples.
- `TIMEOUT`, 1024: valid samples allowed without a trigger before capture is forced; 0 disables auto-trigger; counter is 16 bits.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `sample`  in  8  audio sample, unsigned offset binary.
- `sample_valid`  in  1  one-cycle strobe; `sample` is valid this cycle.
- `frame_done`  in  1  one-cycle pulse after the last visible pixel of a frame.
- `write_enable`  out  1  RAM write strobe, registered.
- `write_address`  out  9  {bank, index[7:0]}, registered.
- `write_sample`  out  8  data to RAM, registered.
- `read_index`  out  1  bank currently displayed.
- `state`  out  2  ARMING=0, ACTIVE=1, CAPTURE=2, WAIT=3.
- `trig_auto`  out  1  1 when the most recent capture was started by timeout; updated at capture start.

## Operation
- Write bank is always `~read_index`. `write_address` = {~read_index, count}.
- **ARMING:**
  - Each valid sample with `sample < TRIG_LEVEL` moves the FSM to ACTIVE.
  - The timeout counter clears on entry to ARMING.
- **ACTIVE:**
  - A valid sample with `sample >= TRIG_LEVEL` is a trigger.
  - On a trigger, that sample is written at index 0, count becomes 1, `trig_auto` becomes 0, and the FSM moves to CAPTURE.
- **Timeout:**
  - The counter increments on every valid sample in ARMING or ACTIVE.
  - If `TIMEOUT` != 0 and the current valid sample is the `TIMEOUT`-th without a trigger, capture is forced.
  - On a forced capture, that sample is written at index 0, count becomes 1, `trig_auto` becomes 1, and the FSM moves to CAPTURE.
  - If a trigger and the timeout occur on the same sample, the trigger wins and `trig_auto` is 0.
- **CAPTURE:**
  - Every valid sample is written at the current count; count increments as 8 bits.
  - On the sample written at index 255, count wraps to 0 and the FSM moves to WAIT.
  - No sample is dropped or duplicated.
- **WAIT:**
  - Valid samples are ignored.
  - On `frame_done`, `read_index` toggles and the FSM moves to ARMING.
- `frame_done` is ignored in every state except WAIT.
- At most one bank swap occurs per capture, and a swap only happens after all 256 writes have been issued.
- **Reset** (any time, including mid-capture):
  - FSM returns to ARMING; `read_index`, `write_enable`, `write_address`, `write_sample`, `trig_auto`, count and the timeout counter all become 0.
  - A partially written bank is abandoned; there is no cleanup write.

## Timing
- Write latency is 1 cycle: `sample_valid` accepted at edge N drives `write_enable`=1, the address and the data during cycle N+1.
- `write_enable` is high for exactly one cycle per written sample.
- `state` updates at the same edge that registers the write.
- The earliest possible swap: `frame_done` in the cycle where the final (index 255) `write_enable` is high. `read_index` then toggles at the following edge, so the last write and the bank swap never conflict.
- `read_index` changes only on an accepted `frame_done` in WAIT. The display sees a stable bank for an entire frame.
- Back-to-back `sample_valid` (every cycle) is supported with one write per cycle.
- Throughput: one capture per frame at most. Samples arriving in WAIT are lost by design.

## Test plan
- **Reset:** assert `reset` 2 cycles mid-CAPTURE, with `read_index`=1 beforehand -> next cycle `state`=0, `read_index`=0, `write_enable`=0, `write_address`=0, `write_sample`=0, `trig_auto`=0.
- **Triggered capture:** with `read_index`=0, feed 100, 120, 140, 160, ... one per cycle -> 140 written at address 9'h100 one cycle after acceptance; addresses 9'h100..9'h1FF written in order with no gaps; `trig_auto`=0; `state`=3 after the 256th write.
- **Bank swap:** `frame_done` pulsed in CAPTURE -> ignored. Then `frame_done` pulsed in WAIT -> `read_index` 0->1 next cycle, `state`=0, and the next capture writes 9'h000..9'h0FF.
- **Auto-trigger:** constant `sample`=200 with `TIMEOUT`=16 -> the 16th valid sample is written at index 0, `trig_auto`=1, and 256 writes follow. With `TIMEOUT`=0 the FSM stays in ARMING indefinitely.
- **Sparse samples and ignored input:** `sample_valid` every 3rd cycle -> exactly one write per strobe with the address incrementing by 1. Samples supplied in WAIT produce no writes.
- **Simultaneous trigger and timeout:** arrange for the `TIMEOUT`-th sample to be a rising crossing -> capture starts with `trig_auto`=0.
